// File: rtl/cpu_pipe_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pipe_pkg
// Shared definitions for the CPU pipeline boundary registers.
//   INS_W      : instruction word width in bits
//   MIPS_NOP   : canonical bubble (NOP) instruction word
//   ins_word_t : instruction word type
// No ports (package).
// ----------------------------------------------------------------------------
package cpu_pipe_pkg;

  localparam int unsigned INS_W = 32;
  localparam logic [INS_W-1:0] MIPS_NOP = 32'h0000_0000;

  typedef logic [INS_W-1:0] ins_word_t;

endpackage : cpu_pipe_pkg

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping. Cleared only by rst.
// Ports:
//   clk   in  1      clock
//   rst   in  1      asynchronous active-high reset (count -> 0)
//   inc   in  1      increment request for this cycle
//   count out CNT_W  current count value (registered)
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Saturating count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {CNT_W{1'b0}};
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule : sat_counter

// File: rtl/pipe_stage_buf.sv
// ----------------------------------------------------------------------------
// pipe_stage_buf
// Pipeline boundary register with valid/ready handshake and a 2-entry skid
// buffer (main + skid). in_ready depends only on local state and flush, so
// the upstream stage sees no combinational path from out_ready. A synchronous
// flush squashes all held entries; empty output slots present NOP_VALUE.
//
// Optional build macro: PIPE_STAGE_PERF_EN adds saturating stall/flush
// performance counters (perf_stall_cnt, perf_flush_cnt).
//
// Ports:
//   clk            in  1      clock, posedge only
//   rst            in  1      asynchronous active-high reset
//   flush          in  1      synchronous squash of held entries
//   in_valid       in  1      upstream has data
//   in_ready       out 1      stage accepts this cycle
//   in_data        in  WIDTH  upstream payload
//   out_valid      out 1      main entry holds valid data
//   out_ready      in  1      downstream consumes this cycle
//   out_data       out WIDTH  payload, NOP_VALUE when out_valid=0
//   perf_stall_cnt out CNT_W  (PIPE_STAGE_PERF_EN only) cycles stalled by downstream
//   perf_flush_cnt out CNT_W  (PIPE_STAGE_PERF_EN only) flushes of a non-empty stage
// ----------------------------------------------------------------------------
module pipe_stage_buf
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned       WIDTH     = INS_W,
  parameter logic [WIDTH-1:0]  NOP_VALUE = WIDTH'(MIPS_NOP),
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  logic             main_v_r;
  logic [WIDTH-1:0] main_d_r;
  logic             skid_v_r;
  logic [WIDTH-1:0] skid_d_r;

  logic             in_ready_s;
  logic             in_fire_s;
  logic             out_fire_s;

  // A full skid or a flush blocks intake; out_ready is deliberately not used.
  assign in_ready_s = !skid_v_r && !flush;
  assign in_fire_s  = in_valid && in_ready_s;
  assign out_fire_s = main_v_r && out_ready;

  assign in_ready  = in_ready_s;
  assign out_valid = main_v_r;

  // Output mux: bubbles read as NOP even though main_d_r keeps stale data.
  always_comb begin
    if (main_v_r) begin
      out_data = main_d_r;
    end else begin
      out_data = NOP_VALUE;
    end
  end

  // Main/skid state update. The skid is only ever filled while main is valid
  // and stalled, so skid_v_r implies main_v_r and ordering stays FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_r <= 1'b0;
      skid_v_r <= 1'b0;
      main_d_r <= NOP_VALUE;
      skid_d_r <= NOP_VALUE;
    end else if (flush) begin
      // Data registers are left alone; only validity is squashed.
      main_v_r <= 1'b0;
      skid_v_r <= 1'b0;
    end else if (!main_v_r) begin
      if (in_fire_s) begin
        main_d_r <= in_data;
        main_v_r <= 1'b1;
      end else begin
        main_v_r <= 1'b0;
      end
    end else if (out_fire_s) begin
      if (skid_v_r) begin
        // in_ready was low, so the skid is the only candidate for main.
        main_d_r <= skid_d_r;
        skid_v_r <= 1'b0;
      end else if (in_fire_s) begin
        main_d_r <= in_data;
      end else begin
        main_v_r <= 1'b0;
      end
    end else begin
      if (in_fire_s) begin
        skid_d_r <= in_data;
        skid_v_r <= 1'b1;
      end else begin
        skid_v_r <= skid_v_r;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc_s;
  logic flush_inc_s;

  assign stall_inc_s = main_v_r && !out_ready && !flush;
  assign flush_inc_s = flush && (main_v_r || skid_v_r);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc_s),
    .count (perf_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc_s),
    .count (perf_flush_cnt)
  );
`else
  // CNT_W only sizes the counters; without them it must merely be sane.
  if (CNT_W == 0) begin : g_cnt_w_zero
  end
`endif

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_buf
// Self-checking bench for pipe_stage_buf. The reference is a FIFO queue of
// capacity two: in_ready means "fewer than two held and no flush", out_data is
// the queue head or NOP, and each edge pops on out_fire then pushes on
// in_fire (a flush empties the queue). Counters, when built, follow the
// stall/flush definitions directly with saturation.
// ----------------------------------------------------------------------------
module tb_pipe_stage_buf;

  localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef PIPE_STAGE_PERF_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] perf_stall_cnt;
  logic [CW-1:0] perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .WIDTH     (32),
    .NOP_VALUE (NOP),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] mq[$];
  int          m_stall;
  int          m_flush;
  logic        last_accept;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ready();
    return (mq.size() < 2) && !flush;
  endfunction

  function automatic logic [31:0] m_data();
    if (mq.size() > 0) return mq[0];
    return NOP;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic check_all(input string ph);
    check({ph, ".in_ready"},  {31'd0, in_ready},  {31'd0, m_ready()});
    check({ph, ".out_valid"}, {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
    check({ph, ".out_data"},  out_data,           m_data());
`ifdef PIPE_STAGE_PERF_EN
    check({ph, ".stall_cnt"}, 32'(perf_stall_cnt), 32'(m_stall));
    check({ph, ".flush_cnt"}, 32'(perf_flush_cnt), 32'(m_flush));
`endif
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
  endtask

  // One clock: check outputs for the applied inputs, then advance model and DUT.
  task automatic cycle(input string ph);
    logic        fire_in;
    logic        fire_out;
    logic        fl;
    logic [31:0] d;
    #1;
    check_all(ph);
    fl       = flush;
    fire_in  = in_valid && m_ready();
    fire_out = (mq.size() > 0) && out_ready;
    d        = in_data;
    if ((mq.size() > 0) && !out_ready && !fl && m_stall < (1 << CW) - 1) m_stall++;
    if (fl && (mq.size() > 0) && m_flush < (1 << CW) - 1) m_flush++;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (fire_out) void'(mq.pop_front());
      if (fire_in) mq.push_back(d);
    end
    last_accept = fire_in;
    #1;
  endtask

  task automatic drain(input string ph);
    drive(1'b0, NOP, 1'b1, 1'b0);
    cycle(ph);
    cycle(ph);
    cycle(ph);
  endtask

  initial begin
    logic [31:0] a, b, c, dd;
    a  = 32'hAAAA_0001;
    b  = 32'hAAAA_0002;
    c  = 32'hCCCC_0003;
    dd = 32'h1234_5678;
    last_accept = 1'b0;

    // Power-on reset.
    rst = 1'b1;
    drive(1'b0, NOP, 1'b0, 1'b0);
    model_reset();
    #1;
    check("por.out_valid", {31'd0, out_valid}, 32'd0);
    check("por.out_data", out_data, NOP);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("por.in_ready", {31'd0, in_ready}, 32'd1);
    cycle("idle");

    // Reset mid-stream: load then assert rst between edges.
    drive(1'b1, 32'h2008_0005, 1'b0, 1'b0);
    cycle("load");
    drive(1'b0, NOP, 1'b0, 1'b0);
    check("load.data", out_data, 32'h2008_0005);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst.out_valid", {31'd0, out_valid}, 32'd0);
    check("arst.out_data", out_data, 32'h0000_0000);
    #1;
    rst = 1'b0;
    #1;
    check("arst.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      cycle("stream");
      check("stream.data", out_data, 32'(i));
      check("stream.in_ready", {31'd0, in_ready}, 32'd1);
    end
    drain("stream_drain");

    // Backpressure fills the skid.
    drive(1'b1, a, 1'b0, 1'b0);
    cycle("bp_a");
    drive(1'b1, b, 1'b0, 1'b0);
    cycle("bp_b");
    check("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
    drive(1'b0, NOP, 1'b1, 1'b0);
    check("bp.head_a", out_data, a);
    cycle("bp_pop");
    check("bp.head_b", out_data, b);
    cycle("bp_pop");
    check("bp.empty", {31'd0, out_valid}, 32'd0);

    // Flush with a full skid, C waiting upstream.
    drive(1'b1, a, 1'b0, 1'b0);
    cycle("fl_a");
    drive(1'b1, b, 1'b0, 1'b0);
    cycle("fl_b");
    drive(1'b1, c, 1'b0, 1'b1);
    #1;
    check("fl.in_ready", {31'd0, in_ready}, 32'd0);
    cycle("fl_flush");
    check("fl.valid", {31'd0, out_valid}, 32'd0);
    check("fl.nop", out_data, NOP);
    drive(1'b1, c, 1'b0, 1'b0);
    cycle("fl_c");
    check("fl.c", out_data, c);
    drain("fl_drain");

    // Simultaneous pop and push keeps the skid empty.
    drive(1'b1, a, 1'b0, 1'b0);
    cycle("pp_a");
    drive(1'b1, dd, 1'b1, 1'b0);
    cycle("pp_d");
    check("pp.data", out_data, dd);
    check("pp.in_ready", {31'd0, in_ready}, 32'd1);
    drain("pp_drain");

`ifdef PIPE_STAGE_PERF_EN
    // Fresh counters for the perf checks.
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, a, 1'b0, 1'b0);
    cycle("perf_load");
    drive(1'b0, NOP, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("perf_stall");
    check("perf.stall_sat", 32'(perf_stall_cnt), 32'h0000_000F);
    drive(1'b0, NOP, 1'b0, 1'b1);
    cycle("perf_fl1");
    cycle("perf_fl_empty");
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, b, 1'b0, 1'b0);
      cycle("perf_reload");
      drive(1'b0, NOP, 1'b0, 1'b1);
      cycle("perf_fl");
    end
    drive(1'b0, NOP, 1'b1, 1'b0);
    cycle("perf_after");
    check("perf.flush_cnt", 32'(perf_flush_cnt), 32'd3);
`endif

    // Randomized traffic; upstream holds data until it is accepted.
    drive(1'b0, NOP, 1'b1, 1'b0);
    last_accept = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic [31:0] d;
      if (in_valid && !last_accept && !flush) begin
        v = in_valid;
        d = in_data;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = $urandom;
      end
      drive(v, d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      cycle("rand");
    end
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_pipe_stage_buf
